// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : PC owner plus DEPTH-entry (addr, inst) circular queue feeding
//               decode over valid/ready. Define IFQ_BYPASS_EN for the
//               zero-latency empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = 'h13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [XLEN-1:0]            rom_addr_o,
    input  logic [XLEN-1:0]            rom_inst_i,
    input  logic                       hold_i,
    input  logic                       jump_en_i,
    input  logic [XLEN-1:0]            jump_addr_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_inst_o,
    output logic [XLEN-1:0]            out_inst_addr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] addr_mem_q [DEPTH];
    logic [XLEN-1:0] inst_mem_q [DEPTH];

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_bypass;
    logic            w_wr;
    logic [XLEN-1:0] w_jump_target;

    assign w_empty       = (count_q == '0);
    assign w_full        = (count_q == CW'(DEPTH));
    assign w_pop         = ~w_empty & out_ready_i & ~jump_en_i;
    assign w_push        = ~jump_en_i & ~hold_i & (~w_full | w_pop);
    assign w_jump_target = jump_addr_i & ~XLEN'(3);

`ifdef IFQ_BYPASS_EN
    // Empty queue with a ready consumer: hand the fetched word straight through.
    assign w_bypass = w_empty & w_push & out_ready_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_wr = w_push & ~w_bypass;

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(w_wr) - CW'(w_pop);
        if (jump_en_i) begin
            pc_d     = w_jump_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) pc_d     = pc_q + XLEN'(4);
            if (w_wr)   wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            addr_mem_q[wr_ptr_q] <= pc_q;
            inst_mem_q[wr_ptr_q] <= rom_inst_i;
        end
    end

    assign rom_addr_o  = pc_q;
    assign count_o     = count_q;
    assign out_valid_o = (~w_empty & ~jump_en_i) | w_bypass;

    always_comb begin
        out_inst_o      = NOP_INST;
        out_inst_addr_o = '0;
        if (w_bypass) begin
            out_inst_o      = rom_inst_i;
            out_inst_addr_o = pc_q;
        end else if (!w_empty) begin
            out_inst_o      = inst_mem_q[rd_ptr_q];
            out_inst_addr_o = addr_mem_q[rd_ptr_q];
        end
    end

endmodule
`default_nettype wire
